// File: rtl/boot_loader.sv
// Launch sequencer: streams a byte image into data memory, holds and releases the CPU,
// waits for done (or the watchdog), then streams a result window back out.
module boot_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned LOAD_LEN   = 256,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_LEN   = 8,
  parameter int unsigned RST_HOLD   = 2,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dm_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              cpu_reset,
  input  logic              cpu_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              finished,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DUMP,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_in_ready;
  logic        r_dm_sel;
  logic        r_cpu_reset;
  logic        r_out_valid;
  logic        r_finished;
  logic        r_timeout;
  logic        w_timeout_set;
  logic        w_load_hs;
  logic        w_dump_hs;

  assign w_load_hs = (r_state == S_LOAD) && in_valid && r_in_ready;
  assign w_dump_hs = (r_state == S_DUMP) && out_ready && r_out_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_set = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (LOAD_LEN == 0) begin
          w_state_nxt = S_HOLD;
        end else if (w_load_hs) begin
          if (r_cnt == LOAD_LEN - 1) w_state_nxt = S_HOLD;
          else                       w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == RST_HOLD - 1) w_state_nxt = S_RUN;
        else                       w_cnt_nxt   = r_cnt + 32'd1;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + 32'd1;
        // done has priority so a late-but-valid finish never reports a timeout
        if (cpu_done) begin
          w_state_nxt = S_DUMP;
        end else if (r_cnt == MAX_CYCLES - 1) begin
          w_state_nxt   = S_DUMP;
          w_timeout_set = 1'b1;
        end
      end
      S_DUMP: begin
        if (DUMP_LEN == 0) begin
          w_state_nxt = S_FIN;
        end else if (w_dump_hs) begin
          if (r_cnt == DUMP_LEN - 1) w_state_nxt = S_FIN;
          else                       w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      S_FIN:   w_state_nxt = S_FIN;
      default: w_state_nxt = S_LOAD;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_dm_sel    <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_out_valid <= 1'b0;
      r_finished  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_dm_sel    <= (w_state_nxt != S_RUN);
      r_cpu_reset <= (w_state_nxt != S_RUN);
      r_out_valid <= (w_state_nxt == S_DUMP) && (DUMP_LEN != 0);
      r_finished  <= (w_state_nxt == S_FIN);
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    out_data = '0;
    unique case (r_state)
      S_LOAD: begin
        dm_addr  = ADDR_W'(LOAD_BASE + r_cnt);
        dm_wdata = in_data;
        dm_we    = w_load_hs;
      end
      S_DUMP: begin
        dm_addr  = ADDR_W'(DUMP_BASE + r_cnt);
        out_data = dm_rdata;
      end
      default: ;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign dm_sel    = r_dm_sel;
  assign cpu_reset = r_cpu_reset;
  assign out_valid = r_out_valid;
  assign finished  = r_finished;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: instance B (base 1, watchdog 16) runs a per-cycle vector table;
// instance A (base fe, 8-byte dump) covers wrap, fake CPU run/dump and mid-dump reset.
module tb_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic checkn(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- instance B ----------------
  logic       rst_b = 1'b1;
  logic       in_valid_b = 1'b0, in_ready_b, dm_sel_b, dm_we_b, cpu_reset_b;
  logic       cpu_done_b = 1'b0, out_valid_b, out_ready_b = 1'b0, finished_b, timeout_b;
  logic [7:0] in_data_b = 8'h00, dm_addr_b, dm_wdata_b, dm_rdata_b, out_data_b;
  logic [7:0] memB [256] = '{default: 8'h00};
  int unsigned wr_n_b = 0;

  boot_loader #(
    .ADDR_W(8), .DATA_W(8), .LOAD_BASE(1), .LOAD_LEN(4), .DUMP_BASE(1),
    .DUMP_LEN(4), .RST_HOLD(2), .MAX_CYCLES(16)
  ) u_b (
    .clk(clk), .reset(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .dm_sel(dm_sel_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_we(dm_we_b), .dm_rdata(dm_rdata_b), .cpu_reset(cpu_reset_b), .cpu_done(cpu_done_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
    .finished(finished_b), .timeout(timeout_b)
  );

  assign dm_rdata_b = memB[dm_addr_b];
  always @(posedge clk) begin
    if (dm_sel_b && dm_we_b) begin
      memB[dm_addr_b] <= dm_wdata_b;
      wr_n_b          <= wr_n_b + 1;
    end
  end

  // ---------------- instance A ----------------
  logic       rst_a = 1'b1;
  logic       in_valid_a = 1'b0, in_ready_a, dm_sel_a, dm_we_a, cpu_reset_a;
  logic       cpu_done_a = 1'b0, out_valid_a, out_ready_a = 1'b0, finished_a, timeout_a;
  logic [7:0] in_data_a = 8'h00, dm_addr_a, dm_wdata_a, dm_rdata_a, out_data_a;
  logic       cpu_we_a = 1'b0;
  logic [7:0] cpu_addr_a = 8'h00, cpu_wdata_a = 8'h00;
  logic [7:0] memA [256] = '{default: 8'h00};
  logic [7:0] wr_addr_a [16];
  int unsigned wr_n_a = 0;

  boot_loader #(
    .ADDR_W(8), .DATA_W(8), .LOAD_BASE(8'hfe), .LOAD_LEN(4), .DUMP_BASE(0),
    .DUMP_LEN(8), .RST_HOLD(2), .MAX_CYCLES(4096)
  ) u_a (
    .clk(clk), .reset(rst_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .dm_sel(dm_sel_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
    .dm_we(dm_we_a), .dm_rdata(dm_rdata_a), .cpu_reset(cpu_reset_a), .cpu_done(cpu_done_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
    .finished(finished_a), .timeout(timeout_a)
  );

  // The fake CPU owns the memory port only while the loader releases it.
  assign dm_rdata_a = memA[dm_addr_a];
  always @(posedge clk) begin
    if (dm_sel_a) begin
      if (dm_we_a) begin
        memA[dm_addr_a]       <= dm_wdata_a;
        wr_addr_a[wr_n_a % 16] <= dm_addr_a;
        wr_n_a                <= wr_n_a + 1;
      end
    end else if (cpu_we_a) begin
      memA[cpu_addr_a] <= cpu_wdata_a;
    end
  end

  // ---------------- vector table for B ----------------
  typedef struct packed {
    logic [7:0] rep;
    logic [2:0] inf;   // {in_valid, out_ready, cpu_done}
    logic [7:0] id;
    logic [6:0] ef;    // {in_ready, dm_we, cpu_reset, dm_sel, out_valid, finished, timeout}
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] od;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] rep, input logic [2:0] inf, input logic [7:0] id,
                              input logic [6:0] ef, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] od);
    mk = '{rep: rep, inf: inf, id: id, ef: ef, addr: addr, wdata: wdata, od: od};
  endfunction

  vec_t vecs [17];
  logic [7:0] exp_b [6] = '{8'h00, 8'h03, 8'hff, 8'hff, 8'hfb, 8'h00};

  // ---------------- A sequences ----------------
  task automatic load_a(input logic [31:0] w, input string tag);
    int unsigned sent  = 0;
    int unsigned guard = 0;
    int unsigned n0    = wr_n_a;
    in_valid_a = 1'b1;
    while (sent < 4 && guard < 40) begin
      in_data_a = w[31 - 8*sent -: 8];
      #1;
      if (in_ready_a) sent++;
      @(negedge clk);
      guard++;
    end
    in_valid_a = 1'b0;
    checkn({tag, " bytes accepted"}, sent, 4);
    checkn({tag, " write count"}, wr_n_a - n0, 4);
    for (int unsigned i = 0; i < 4; i++) begin
      check8($sformatf("%s wr addr %0d", tag, i), wr_addr_a[(n0 + i) % 16], 8'(8'hfe + i));
      check8($sformatf("%s mem byte %0d", tag, i), memA[8'(8'hfe + i)], w[31 - 8*i -: 8]);
    end
  endtask

  task automatic run_a(input string tag);
    int unsigned guard = 0;
    while (cpu_reset_a !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkn({tag, " hold cycles"}, guard, 2);
    check1({tag, " cpu released"}, cpu_reset_a, 1'b0);
    check1({tag, " dm_sel to cpu"}, dm_sel_a, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      cpu_we_a = 1'b1; cpu_addr_a = 8'(i); cpu_wdata_a = 8'(i);
      @(negedge clk);
    end
    cpu_we_a = 1'b0;
    repeat (12) @(negedge clk);
    cpu_done_a = 1'b1;
    #1;
    check1({tag, " no dump before done"}, out_valid_a, 1'b0);
    @(negedge clk);
    cpu_done_a = 1'b0;
    #1;
    check1({tag, " dump valid after done"}, out_valid_a, 1'b1);
    check1({tag, " cpu frozen in dump"}, cpu_reset_a, 1'b1);
    check1({tag, " dm_sel in dump"}, dm_sel_a, 1'b1);
    check1({tag, " no timeout"}, timeout_a, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = mk(1,  3'b101, 8'h03, 7'b0011000, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(1,  3'b101, 8'h03, 7'b1111000, 8'h01, 8'h03, 8'h00);
    vecs[2]  = mk(1,  3'b001, 8'h55, 7'b1011000, 8'h00, 8'h00, 8'h00);
    vecs[3]  = mk(1,  3'b101, 8'hff, 7'b1111000, 8'h02, 8'hff, 8'h00);
    vecs[4]  = mk(1,  3'b001, 8'h55, 7'b1011000, 8'h00, 8'h00, 8'h00);
    vecs[5]  = mk(1,  3'b101, 8'hff, 7'b1111000, 8'h03, 8'hff, 8'h00);
    vecs[6]  = mk(1,  3'b001, 8'h55, 7'b1011000, 8'h00, 8'h00, 8'h00);
    vecs[7]  = mk(1,  3'b101, 8'hfb, 7'b1111000, 8'h04, 8'hfb, 8'h00);
    vecs[8]  = mk(2,  3'b101, 8'h77, 7'b0011000, 8'h00, 8'h00, 8'h00);
    vecs[9]  = mk(16, 3'b000, 8'h00, 7'b0000000, 8'h00, 8'h00, 8'h00);
    vecs[10] = mk(2,  3'b000, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'h03);
    vecs[11] = mk(1,  3'b010, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'h03);
    vecs[12] = mk(1,  3'b010, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'hff);
    vecs[13] = mk(1,  3'b000, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'hff);
    vecs[14] = mk(1,  3'b010, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'hff);
    vecs[15] = mk(1,  3'b010, 8'h00, 7'b0011101, 8'h00, 8'h00, 8'hfb);
    vecs[16] = mk(3,  3'b111, 8'h66, 7'b0011011, 8'h00, 8'h00, 8'h00);

    // B: reset state with a pending in_valid
    @(negedge clk);
    in_valid_b = 1'b1;
    #1;
    check1("B rst in_ready", in_ready_b, 1'b0);
    check1("B rst dm_we", dm_we_b, 1'b0);
    check1("B rst cpu_reset", cpu_reset_b, 1'b1);
    check1("B rst dm_sel", dm_sel_b, 1'b1);
    check1("B rst out_valid", out_valid_b, 1'b0);
    check1("B rst finished", finished_b, 1'b0);
    check1("B rst timeout", timeout_b, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;

    for (int r = 0; r < 17; r++) begin
      for (int unsigned k = 0; k < vecs[r].rep; k++) begin
        {in_valid_b, out_ready_b, cpu_done_b} = vecs[r].inf;
        in_data_b = vecs[r].id;
        #1;
        check1($sformatf("B v%0d.%0d in_ready", r, k), in_ready_b, vecs[r].ef[6]);
        check1($sformatf("B v%0d.%0d dm_we", r, k), dm_we_b, vecs[r].ef[5]);
        check1($sformatf("B v%0d.%0d cpu_reset", r, k), cpu_reset_b, vecs[r].ef[4]);
        check1($sformatf("B v%0d.%0d dm_sel", r, k), dm_sel_b, vecs[r].ef[3]);
        check1($sformatf("B v%0d.%0d out_valid", r, k), out_valid_b, vecs[r].ef[2]);
        check1($sformatf("B v%0d.%0d finished", r, k), finished_b, vecs[r].ef[1]);
        check1($sformatf("B v%0d.%0d timeout", r, k), timeout_b, vecs[r].ef[0]);
        if (vecs[r].ef[5]) begin
          check8($sformatf("B v%0d.%0d dm_addr", r, k), dm_addr_b, vecs[r].addr);
          check8($sformatf("B v%0d.%0d dm_wdata", r, k), dm_wdata_b, vecs[r].wdata);
        end
        if (vecs[r].ef[2])
          check8($sformatf("B v%0d.%0d out_data", r, k), out_data_b, vecs[r].od);
        @(negedge clk);
      end
    end
    in_valid_b = 1'b0; out_ready_b = 1'b0; cpu_done_b = 1'b0;
    checkn("B write count", wr_n_b, 4);
    for (int unsigned i = 0; i < 6; i++)
      check8($sformatf("B mem[%0d]", i), memB[i], exp_b[i]);

    // A: wrapped load, fake CPU run, dump with random backpressure
    rst_a = 1'b0;
    load_a(32'ha1a2a3a4, "A1");
    run_a("A1");
    begin
      int unsigned got   = 0;
      int unsigned guard = 0;
      while (got < 8 && guard < 200) begin
        out_ready_a = 1'($urandom_range(0, 1));
        #1;
        if (out_valid_a) begin
          check8($sformatf("A1 dump data idx %0d", got), out_data_a, 8'(got));
          if (out_ready_a) got++;
        end
        @(negedge clk);
        guard++;
      end
      out_ready_a = 1'b0;
      checkn("A1 dump count", got, 8);
    end
    in_valid_a = 1'b1; cpu_done_a = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("A1 fin%0d finished", i), finished_a, 1'b1);
      check1($sformatf("A1 fin%0d timeout", i), timeout_a, 1'b0);
      check1($sformatf("A1 fin%0d out_valid", i), out_valid_a, 1'b0);
      check1($sformatf("A1 fin%0d in_ready", i), in_ready_a, 1'b0);
      check1($sformatf("A1 fin%0d dm_we", i), dm_we_a, 1'b0);
      check1($sformatf("A1 fin%0d cpu_reset", i), cpu_reset_a, 1'b1);
      @(negedge clk);
    end
    in_valid_a = 1'b0; cpu_done_a = 1'b0;
    #2 rst_a = 1'b1;
    #1 check1("A1 rst clears finished", finished_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;

    // A: reload restarts at base, then reset in the middle of the third dump byte
    load_a(32'hb1b2b3b4, "A2");
    run_a("A2");
    out_ready_a = 1'b1;
    for (int unsigned b = 0; b < 2; b++) begin
      #1;
      check8($sformatf("A2 dump byte %0d", b), out_data_a, 8'(b));
      @(negedge clk);
    end
    #1;
    check1("A2 third byte valid", out_valid_a, 1'b1);
    check8("A2 third byte data", out_data_a, 8'h02);
    #2 rst_a = 1'b1;
    #1;
    check1("A2 midreset cpu_reset", cpu_reset_a, 1'b1);
    check1("A2 midreset out_valid", out_valid_a, 1'b0);
    check1("A2 midreset dm_sel", dm_sel_a, 1'b1);
    check1("A2 midreset in_ready", in_ready_a, 1'b0);
    check1("A2 midreset dm_we", dm_we_a, 1'b0);
    check1("A2 midreset finished", finished_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    out_ready_a = 1'b0;
    load_a(32'hc1c2c3c4, "A3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
